// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and quantize helpers for the FIR/beamformer chain
package fir_pkg;
  localparam int IN_W_DEF = 111;
  localparam int OUT_W_DEF = 16;
  localparam int SHIFT_DEF = 15;
  localparam int SAT_W = IN_W_DEF + 1;
  localparam logic signed [OUT_W_DEF-1:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [OUT_W_DEF-1:0] OUT_MIN = 16'sh8000;
  typedef struct packed {
    logic sat;
    logic [OUT_W_DEF-1:0] q;
  } qsat_t;
  function automatic qsat_t sat_out(input logic signed [SAT_W-1:0] x);
    logic signed [SAT_W-1:0] hi, lo;
    hi = SAT_W'(OUT_MAX);
    lo = SAT_W'(OUT_MIN);
    sat_out.sat = (x > hi) || (x < lo);
    sat_out.q = x > hi ? OUT_MAX : x < lo ? OUT_MIN : x[OUT_W_DEF-1:0];
  endfunction
  function automatic qsat_t round_shift_sat(input logic signed [IN_W_DEF-1:0] x, input int unsigned sh);
    logic signed [SAT_W-1:0] r;
    r = (SAT_W'(x) + (SAT_W'(1) <<< (sh - 1))) >>> sh;
    return sat_out(r);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO; push while full is ignored unless a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  // accept a write when there is room or a slot frees up this cycle
  always_comb begin
    wr = push_i && (!full_o || pop_i);
    rd = pop_i && !empty_o;
  end
  // pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(rd);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
  // storage needs no reset: reads are gated by empty
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/fir_output_quantizer.sv
// fir_output_quantizer: round, saturate, decimate and buffer FIR accumulator samples
module fir_output_quantizer
  import fir_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DECIM = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clr_flags,
  output logic                    sat_flag,
  output logic                    ovf_flag,
  output logic [7:0]              drop_cnt
);
  localparam int PH_W = DECIM > 1 ? $clog2(DECIM) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) <<< (SHIFT - 1);
  logic s1_v_q, s2_v_q;
  logic signed [IN_W:0] r_q, r_d;
  logic [OUT_W-1:0] q_q;
  logic [PH_W-1:0] ph_q, ph_d;
  logic sat_q, sat_d, ovf_q, ovf_d;
  logic [7:0] drop_q, drop_d;
  qsat_t qs;
  logic push, pop, drop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  assign out_valid = !fifo_empty;
  assign sat_flag = sat_q;
  assign ovf_flag = ovf_q;
  assign drop_cnt = drop_q;
  // round/shift, saturate, decimation phase and sticky status next-state; set beats clear
  always_comb begin
    r_d = ((IN_W+1)'(in_data) + RND) >>> SHIFT;
    qs = sat_out(r_q);
    ph_d = s2_v_q ? (ph_q == PH_W'(DECIM - 1) ? '0 : ph_q + 1'b1) : ph_q;
    push = s2_v_q && ph_q == '0;
    pop = out_valid && out_ready;
    drop = push && fifo_full && !pop;
    sat_d = (s1_v_q && qs.sat) || (!clr_flags && sat_q);
    ovf_d = drop || (!clr_flags && ovf_q);
    drop_d = clr_flags ? {7'd0, drop} : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  // pipeline valids, decimation phase and status; data stages load only on their valid
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      ph_q <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      s1_v_q <= in_valid;
      s2_v_q <= s1_v_q;
      ph_q <= ph_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
    if (in_valid) r_q <= r_d;
    if (s1_v_q) q_q <= qs.q;
  end
  sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push && (!fifo_full || pop)),
    .pop_i(pop),
    .data_i(q_q),
    .data_o(out_data),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_cnt)
  );
  // occupancy beyond DEPTH would mean the push gating is broken
  always_ff @(posedge clk) begin
    if (!rst) assert (fifo_cnt <= CW'(DEPTH));
  end
endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb_fir_output_quantizer: directed checks of rounding, saturation, decimation, overflow and reset
module tb_fir_output_quantizer;
  logic clk = 1'b0;
  logic rst, iv, iv4, out_ready, out_ready4, clr, clr4;
  logic [110:0] in_data;
  logic [15:0] od, od4;
  logic ov, sat, ovf, ov4, sat4, ovf4;
  logic [7:0] dc, dc4;
  int n_chk = 0;
  int n_fail = 0;
  longint rv [7] = '{262144, 16384, -16384, -49152, -32768, longint'(1) <<< 40, -(longint'(1) <<< 40)};
  logic [15:0] re [7] = '{16'd8, 16'd1, 16'd0, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] got4 [4];
  int n4 = 0;
  always #5 clk = ~clk;
  fir_output_quantizer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv), .out_data(od), .out_valid(ov),
    .out_ready(out_ready), .clr_flags(clr), .sat_flag(sat), .ovf_flag(ovf), .drop_cnt(dc)
  );
  fir_output_quantizer #(.DECIM(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(iv4), .out_data(od4), .out_valid(ov4),
    .out_ready(out_ready4), .clr_flags(clr4), .sat_flag(sat4), .ovf_flag(ovf4), .drop_cnt(dc4)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input longint v, input logic a, input logic b);
    in_data = 111'(v);
    iv = a;
    iv4 = b;
  endtask
  initial begin
    rst = 1'b1; iv = 1'b0; iv4 = 1'b0; in_data = '0;
    out_ready = 1'b1; out_ready4 = 1'b1; clr = 1'b0; clr4 = 1'b0;
    tick(2);
    rst = 1'b0;
    check("rst_valid", ov, 0);
    check("rst_data", od, 0);
    check("rst_sat", sat, 0);
    check("rst_ovf", ovf, 0);
    check("rst_drop", dc, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 5) check("sat_clean", sat, 0);
      drive(rv[i], 1'b1, 1'b0);
      tick();
      iv = 1'b0;
      tick();
      check("latency", ov, 0);
      tick();
      check("out_valid", ov, 1);
      check("quant", od, re[i]);
      tick();
    end
    check("sat_set", sat, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr", sat, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(longint'(k) <<< 15, 1'b1, 1'b0);
      tick();
    end
    iv = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("thru", od, k);
      tick();
    end
    check("thru_done", ov, 0);
    for (int i = 0; i < 14; i++) begin
      drive(longint'(i + 1) <<< 15, 1'b0, i < 8);
      tick();
      if (ov4) begin
        if (n4 < 4) got4[n4] = od4;
        n4++;
      end
    end
    iv4 = 1'b0;
    check("dec_count", n4, 2);
    check("dec_first", got4[0], 1);
    check("dec_second", got4[1], 5);
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(longint'(k) <<< 15, 1'b1, 1'b0);
      tick();
    end
    iv = 1'b0;
    tick(3);
    check("ovf_valid", ov, 1);
    check("ovf_flag", ovf, 1);
    check("ovf_drop", dc, 2);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain", od, k);
      tick();
    end
    check("drain_empty", ov, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_drop", dc, 0);
    out_ready = 1'b0;
    drive(longint'(1) <<< 40, 1'b1, 1'b1);
    tick();
    drive(longint'(2) <<< 15, 1'b1, 1'b0);
    tick();
    drive(longint'(3) <<< 15, 1'b1, 1'b0);
    tick();
    iv = 1'b0;
    tick(2);
    check("pre_rst_valid", ov, 1);
    check("pre_rst_sat", sat, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", ov, 0);
    check("mid_rst_data", od, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_drop", dc, 0);
    drive(longint'(9) <<< 15, 1'b0, 1'b1);
    tick();
    iv4 = 1'b0;
    tick(2);
    check("phase_rst_valid", ov4, 1);
    check("phase_rst_data", od4, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
